// File: rtl/fft_ctrl_pkg.sv
// Shared defaults and state encoding for the FFT streaming sequencer.
package fft_ctrl_pkg;

    localparam int unsigned LGSIZE_DEF   = 10;
    localparam int unsigned IW_DEF       = 16;
    localparam int unsigned OW_DEF       = 16;
    localparam int unsigned TAGDEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAD   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fft_tag_fifo.sv
// One-bit frame-tag FIFO: records whether each frame in the FFT pipeline carries real data.
module fft_tag_fifo
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = TAGDEPTH_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Status flags; an empty FIFO presents a padding tag.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        head    = !empty && mem[rd_ptr[AW-1:0]];
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Pointer update.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Tag storage.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fft_stream_ctrl.sv
// Valid/ready sequencer around a pipelined FFT: gates the FFT clock enable,
// frames results with first/last markers and flushes partial frames.
module fft_stream_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned LGSIZE   = LGSIZE_DEF,
    parameter int unsigned IW       = IW_DEF,
    parameter int unsigned OW       = OW_DEF,
    parameter int unsigned TAGDEPTH = TAGDEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [2*IW-1:0]   s_data,
    input  logic              i_flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [2*OW-1:0]   m_data,
    output logic              m_first,
    output logic              m_last,
    output logic              o_busy,
    output logic              o_fft_ce,
    output logic [2*IW-1:0]   o_fft_sample,
    input  logic [2*OW-1:0]   i_fft_result,
    input  logic              i_fft_sync
);

    localparam int unsigned RCW = $clog2(TAGDEPTH + 1);

    state_t            state;
    state_t            state_nxt;
    logic [LGSIZE-1:0] in_cnt;
    logic [LGSIZE-1:0] in_cnt_nxt;
    logic [LGSIZE-1:0] out_cnt;
    logic [RCW-1:0]    real_cnt;
    logic [RCW-1:0]    real_cnt_nxt;
    logic              fresh;
    logic              primed;
    logic              has_real;

    logic src_ok;
    logic drain_done;
    logic primed_eff;
    logic consume;
    logic out_room;
    logic in_wrap;
    logic tag_push;
    logic tag_pop;
    logic tag_din;
    logic tag_full;
    logic tag_empty;
    logic tag_head;

    fft_tag_fifo #(.DEPTH(TAGDEPTH)) u_tags (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push    (tag_push),
        .pop     (tag_pop),
        .din     (tag_din),
        .full    (tag_full),
        .empty   (tag_empty),
        .head    (tag_head)
    );

    // Enable gating, output handshake and tag bookkeeping.
    always_comb begin
        // Hold the enable once the drain is complete so the next frame starts clean.
        drain_done   = (state == ST_DRAIN) && (real_cnt == '0) && (in_cnt == '0);
        src_ok       = (state == ST_RUN) ? s_valid : !drain_done;
        primed_eff   = primed || i_fft_sync;
        consume      = fresh && primed_eff && (m_ready || !tag_head);
        out_room     = !fresh || !primed_eff || consume;
        o_fft_ce     = !i_reset && src_ok && out_room && !((in_cnt == '1) && tag_full);
        s_ready      = o_fft_ce && (state == ST_RUN);
        o_fft_sample = (state == ST_RUN) ? s_data : '0;
        in_wrap      = o_fft_ce && (in_cnt == '1);
        in_cnt_nxt   = o_fft_ce ? in_cnt + LGSIZE'(1) : in_cnt;
        tag_push     = in_wrap;
        tag_din      = has_real || (state == ST_RUN);
        tag_pop      = consume && (out_cnt == '1);
        real_cnt_nxt = real_cnt;
        if (tag_push && tag_din)            real_cnt_nxt = real_cnt_nxt + RCW'(1);
        if (tag_pop && !tag_empty && tag_head) real_cnt_nxt = real_cnt_nxt - RCW'(1);
        m_valid      = !i_reset && fresh && primed_eff && tag_head;
        m_first      = m_valid && (out_cnt == '0);
        m_last       = m_valid && (out_cnt == '1);
        m_data       = i_fft_result;
        o_busy       = !i_reset && (state != ST_RUN);
    end

    // Next-state logic for the flush sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (i_flush) begin
                    if (in_cnt_nxt != '0)        state_nxt = ST_PAD;
                    else if (real_cnt_nxt != '0) state_nxt = ST_DRAIN;
                end
            end
            ST_PAD:   if (in_wrap)    state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_nxt = ST_RUN;
            default:                  state_nxt = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_RUN;
        else         state <= state_nxt;
    end

    // Input/output counters and output tracking flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            real_cnt <= '0;
            fresh    <= 1'b0;
            primed   <= 1'b0;
            has_real <= 1'b0;
        end else begin
            in_cnt   <= in_cnt_nxt;
            real_cnt <= real_cnt_nxt;
            if (consume)                         out_cnt <= out_cnt + LGSIZE'(1);
            if (fresh && i_fft_sync)             primed  <= 1'b1;
            if (in_wrap)                         has_real <= 1'b0;
            else if (o_fft_ce && state == ST_RUN) has_real <= 1'b1;
            if (o_fft_ce)     fresh <= 1'b1;
            else if (consume) fresh <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Directed bench for fft_stream_ctrl with a delay-line stand-in for the FFT.
module tb_fft_stream_ctrl;

    localparam int unsigned LGSIZE   = 10;
    localparam int unsigned IW       = 16;
    localparam int unsigned OW       = 16;
    localparam int unsigned TAGDEPTH = 4;
    localparam int unsigned N        = 1 << LGSIZE;
    localparam int unsigned LAT      = N + 300;

    logic            i_clk;
    logic            i_reset;
    logic            s_valid;
    logic            s_ready;
    logic [2*IW-1:0] s_data;
    logic            i_flush;
    logic            m_valid;
    logic            m_ready;
    logic [2*OW-1:0] m_data;
    logic            m_first;
    logic            m_last;
    logic            o_busy;
    logic            o_fft_ce;
    logic [2*IW-1:0] o_fft_sample;
    logic [2*OW-1:0] fft_result;
    logic            fft_sync;

    int unsigned     checks  = 0;
    int unsigned     errors  = 0;
    int unsigned     sent    = 0;
    int unsigned     idx     = 0;
    int unsigned     rx_cnt  = 0;
    int unsigned     cyc     = 0;
    bit              bp_mode = 1'b0;
    logic [31:0]     exp_q[$];

    fft_stream_ctrl #(
        .LGSIZE(LGSIZE), .IW(IW), .OW(OW), .TAGDEPTH(TAGDEPTH)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .i_flush      (i_flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_first      (m_first),
        .m_last       (m_last),
        .o_busy       (o_busy),
        .o_fft_ce     (o_fft_ce),
        .o_fft_sample (o_fft_sample),
        .i_fft_result (fft_result),
        .i_fft_sync   (fft_sync)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // FFT stand-in: identity transform with LAT ce-cycles of latency, sync on bin 0.
    logic [2*OW:0]     fmem [LAT];
    int unsigned       fptr;
    logic [LGSIZE-1:0] fcnt;
    always @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(LAT); i++) fmem[i] <= '0;
            fptr       <= 0;
            fcnt       <= '0;
            fft_result <= '0;
            fft_sync   <= 1'b0;
        end else if (o_fft_ce) begin
            {fft_sync, fft_result} <= fmem[fptr];
            fmem[fptr] <= {(fcnt == '0), o_fft_sample};
            fptr       <= (fptr == LAT - 1) ? 0 : fptr + 1;
            fcnt       <= fcnt + LGSIZE'(1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one sample and wait for acceptance; called at a falling edge.
    task automatic send(input logic [31:0] v);
        logic acc;
        acc     = 1'b0;
        s_valid = 1'b1;
        s_data  = v;
        for (int n = 0; n < 20000 && !acc; n++) begin
            #1;
            acc = s_ready;
            @(negedge i_clk);
        end
        s_valid = 1'b0;
        s_data  = '0;
        if (acc) begin
            exp_q.push_back(v);
            sent++;
        end else begin
            chk("send_timeout", 32'(acc), 32'd1);
        end
    endtask

    // Flush pulse; a partial frame is expected back zero-padded.
    task automatic flush();
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        while (sent % N != 0) begin
            exp_q.push_back(32'd0);
            sent++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        #1;
        while (o_busy && n < 20000) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        chk(tag, 32'(o_busy), 32'd0);
        @(negedge i_clk);
    endtask

    task automatic model_reset();
        exp_q.delete();
        sent = 0;
        idx  = 0;
    endtask

    // Sink backpressure at roughly 30% ready.
    initial begin
        forever begin
            @(negedge i_clk);
            if (bp_mode) m_ready = ($urandom_range(0, 99) < 30);
        end
    end

    // Output monitor: data/marker checks, stall stability, no stray results.
    initial begin : mon
        logic        sp;
        logic [31:0] pd;
        logic        pf;
        logic        pl;
        logic [31:0] e;
        sp = 1'b0; pd = '0; pf = 1'b0; pl = 1'b0;
        forever begin
            @(negedge i_clk);
            #3;
            if (i_reset) begin
                sp = 1'b0;
            end else begin
                if (sp) begin
                    chk("hold_valid", 32'(m_valid), 32'd1);
                    chk("hold_data",  m_data, pd);
                    chk("hold_first", 32'(m_first), 32'(pf));
                    chk("hold_last",  32'(m_last), 32'(pl));
                end
                if (m_valid && !m_ready) begin
                    chk("stall_s_ready", 32'(s_ready), 32'd0);
                    chk("stall_ce", 32'(o_fft_ce), 32'd0);
                end
                if (!m_valid && (m_first || m_last)) begin
                    chk("marker_no_valid", 32'({m_first, m_last}), 32'd0);
                end
                if (m_valid && exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(m_valid), 32'd0);
                end else if (m_valid && m_ready) begin
                    e = exp_q.pop_front();
                    chk("out_data",  m_data, e);
                    chk("out_first", 32'(m_first), 32'(idx % N == 0));
                    chk("out_last",  32'(m_last), 32'(idx % N == N - 1));
                    idx++;
                    rx_cnt++;
                end
                sp = m_valid && !m_ready;
                pd = m_data;
                pf = m_first;
                pl = m_last;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int unsigned c1;
        i_reset = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h1234_5678;
        i_flush = 1'b0;
        m_ready = 1'b1;

        // Reset: enable and handshakes held low even with a valid sample offered.
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_ce",      32'(o_fft_ce), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("post_rst_busy",  32'(o_busy), 32'd0);
        chk("post_rst_first", 32'(m_first), 32'd0);
        chk("post_rst_last",  32'(m_last), 32'd0);
        chk("post_rst_valid", 32'(m_valid), 32'd0);
        @(negedge i_clk);

        // Flush with nothing buffered stays in RUN.
        flush();
        #1;
        chk("idle_flush_busy", 32'(o_busy), 32'd0);
        chk("idle_flush_ce",   32'(o_fft_ce), 32'd0);
        repeat (3) @(negedge i_clk);
        #1;
        chk("idle_flush_busy2", 32'(o_busy), 32'd0);
        @(negedge i_clk);

        // Continuous ramp of three frames at one sample per clock.
        rx_cnt = 0;
        c0 = cyc;
        for (int i = 0; i < int'(3 * N); i++) send({16'(i), 16'(3 * N - i)});
        c1 = cyc;
        chk("ramp_cycles", c1 - c0, 3 * N);
        flush();
        #1;
        chk("ramp_drain_busy", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        wait_idle("ramp_idle");
        chk("ramp_left", 32'(exp_q.size()), 32'd0);
        chk("ramp_rx",   rx_cnt, 3 * N);

        // Impulse frame, then flush; nothing may follow the last bin.
        rx_cnt = 0;
        send(32'h7FFF_0000);
        for (int i = 1; i < int'(N); i++) send(32'd0);
        flush();
        #1;
        chk("imp_drain_busy", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        wait_idle("imp_idle");
        chk("imp_left", 32'(exp_q.size()), 32'd0);
        chk("imp_rx",   rx_cnt, N);
        repeat (50) @(negedge i_clk);
        chk("imp_rx_after", rx_cnt, N);

        // Partial frame of 300 samples is zero-padded to one full frame.
        rx_cnt = 0;
        for (int i = 0; i < 300; i++) send(32'hA500_0000 + 32'(i));
        flush();
        #1;
        chk("part_pad_busy", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        wait_idle("part_idle");
        chk("part_left", 32'(exp_q.size()), 32'd0);
        chk("part_rx",   rx_cnt, N);

        // Random sink backpressure across two frames.
        rx_cnt  = 0;
        bp_mode = 1'b1;
        for (int i = 0; i < int'(N + 200); i++) send($urandom());
        flush();
        #1;
        chk("bp_busy", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        wait_idle("bp_idle");
        bp_mode = 1'b0;
        m_ready = 1'b1;
        chk("bp_left", 32'(exp_q.size()), 32'd0);
        chk("bp_rx",   rx_cnt, 2 * N);

        // Reset in the middle of input frame 1 while frame 0 is being emitted.
        i_reset = 1'b1;
        model_reset();
        @(negedge i_clk);
        i_reset = 1'b0;
        rx_cnt  = 0;
        for (int i = 0; i < int'(N + 500); i++) send(32'h0300_0000 + 32'(i));
        repeat (2) @(negedge i_clk);
        chk("mid_pre_rx", rx_cnt, N + 500 - LAT);
        i_reset = 1'b1;
        model_reset();
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_first", 32'(m_first), 32'd0);
        chk("mid_rst_last",  32'(m_last), 32'd0);
        chk("mid_rst_ready", 32'(s_ready), 32'd0);
        chk("mid_rst_ce",    32'(o_fft_ce), 32'd0);
        chk("mid_rst_busy",  32'(o_busy), 32'd0);
        @(negedge i_clk);
        rx_cnt = 0;
        for (int i = 0; i < int'(N); i++) send(32'h0C00_0000 + 32'(i));
        flush();
        #1;
        chk("mid_drain_busy", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        wait_idle("mid_idle");
        chk("mid_left", 32'(exp_q.size()), 32'd0);
        chk("mid_rx",   rx_cnt, N);
        repeat (20) @(negedge i_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
